// File: rtl/spi_slave.sv
// SPI mode-0 slave, LSB first: oversampled pins, DATALEN-bit words in both directions,
// one-entry tx buffer and a held rx word behind valid/ready handshakes.
module spi_slave #(
  parameter int DATALEN = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               SCLK,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  input  logic [DATALEN-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [DATALEN-1:0] rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic               overrun,
  output logic               underrun,
  output logic               frame_err,
  input  logic               clear_flags
);
  localparam int BW = (DATALEN > 1) ? $clog2(DATALEN) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATALEN - 1);

  typedef enum logic {IDLE, ACTIVE} state_e;
  state_e state_q, state_d;

  logic [2:0]         sync1_q, sync1_d, sync2_q, sync2_d;  // {SCLK, SS_n, MOSI}
  logic               sclk_dly_q, sclk_dly_d, ss_dly_q, ss_dly_d;
  logic [1:0]         prime_q, prime_d;
  logic               armed_q, armed_d;
  logic [BW-1:0]      bitcnt_q, bitcnt_d;
  logic [DATALEN-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic [DATALEN-1:0] txbuf_q, txbuf_d, rx_data_q, rx_data_d;
  logic               txfull_q, txfull_d, word_done_q, word_done_d;
  logic               rx_valid_q, rx_valid_d, overrun_q, overrun_d;
  logic               underrun_q, underrun_d, frame_err_q, frame_err_d;
  logic               sclk_s, ss_s, mosi_s;
  logic               sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic               slot_start, tx_load, overrun_set, underrun_set;

  assign sclk_s    = sync2_q[2];
  assign ss_s      = sync2_q[1];
  assign mosi_s    = sync2_q[0];
  assign sclk_rise =  sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s &  sclk_dly_q;
  assign ss_rise   =  ss_s   & ~ss_dly_q;
  assign ss_fall   = ~ss_s   &  ss_dly_q;
  assign tx_load   = tx_valid & ~txfull_q;

  always_comb begin
    sync1_d      = {SCLK, SS_n, MOSI};
    sync2_d      = sync1_q;
    sclk_dly_d   = sclk_s;
    ss_dly_d     = ss_s;
    prime_d      = (prime_q == 2'd2) ? prime_q : prime_q + 2'd1;
    // Only arm once a genuine (post-reset) high SS_n has been seen, so a
    // reset released mid-frame never mistakes the reset value for a fall.
    armed_d      = armed_q | ((prime_q == 2'd2) & ss_s);
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    txbuf_d      = txbuf_q;
    txfull_d     = txfull_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    word_done_d  = 1'b0;
    frame_err_d  = 1'b0;
    slot_start   = 1'b0;
    overrun_set  = 1'b0;
    underrun_set = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ss_fall && armed_q) begin
          state_d    = ACTIVE;
          slot_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d     = IDLE;
          frame_err_d = (bitcnt_q != '0);
          bitcnt_d    = '0;
          tx_shift_d  = '0;
        end else begin
          if (word_done_q) slot_start = 1'b1;
          if (sclk_rise) begin
            rx_shift_d = {mosi_s, rx_shift_q[DATALEN-1:1]};
            if (bitcnt_q == LAST_BIT) begin
              bitcnt_d    = '0;
              word_done_d = 1'b1;
            end else begin
              bitcnt_d = bitcnt_q + 1'b1;
            end
          end
          // The fall trailing a word's last bit arrives after the next slot
          // has loaded tx_shift (bitcnt back at 0); it must not shift bit 0 away.
          if (sclk_fall && (bitcnt_q != '0)) tx_shift_d = tx_shift_q >> 1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (slot_start) begin
      bitcnt_d = '0;
      if (txfull_q) begin
        tx_shift_d = txbuf_q;
      end else begin
        tx_shift_d   = '0;
        underrun_set = 1'b1;
      end
    end

    if (slot_start) txfull_d = 1'b0;
    if (tx_load) begin
      txbuf_d  = tx_data;
      txfull_d = 1'b1;
    end

    if (word_done_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    overrun_d  = (overrun_q  & ~clear_flags) | overrun_set;
    underrun_d = (underrun_q & ~clear_flags) | underrun_set;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q     <= 3'b010;
      sync2_q     <= 3'b010;
      sclk_dly_q  <= 1'b0;
      ss_dly_q    <= 1'b1;
      prime_q     <= '0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      txbuf_q     <= '0;
      txfull_q    <= 1'b0;
      word_done_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sclk_dly_q  <= sclk_dly_d;
      ss_dly_q    <= ss_dly_d;
      prime_q     <= prime_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      txbuf_q     <= txbuf_d;
      txfull_q    <= txfull_d;
      word_done_q <= word_done_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign MISO      = (state_q == ACTIVE) & tx_shift_q[0];
  assign tx_ready  = ~txfull_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign underrun  = underrun_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave (DATALEN=8): a word-level model of the link
// predicts received words, MISO bits and flags; literals pin the key results.
module tb_spi_slave;
  localparam int DL   = 8;
  localparam int HALF = 4;

  logic          clock = 1'b0;
  logic          reset, SCLK, SS_n, MOSI, MISO;
  logic [DL-1:0] tx_data, rx_data;
  logic          tx_valid, tx_ready, rx_valid, rx_ready;
  logic          overrun, underrun, frame_err, clear_flags;

  int checks = 0;
  int errors = 0;

  spi_slave #(.DATALEN(DL)) dut (
    .clock(clock), .reset(reset), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .underrun(underrun), .frame_err(frame_err), .clear_flags(clear_flags)
  );

  always #5 clock = ~clock;

  // word-level model of the link
  logic [DL-1:0] tx_q[$];
  logic [DL-1:0] exp_got[$];
  logic [DL-1:0] got[$];
  logic [DL-1:0] exp_rx_data, slot_word, mo1, mo2;
  logic          exp_rx_valid, exp_overrun, exp_underrun, active, slot_pending;
  int            bits_in_word, exp_ferr, ferr_cycles;
  bit            chk_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (frame_err === 1'b1) ferr_cycles++;
    if (!reset && rx_valid === 1'b1 && rx_ready === 1'b1) got.push_back(rx_data);
    if (chk_en) begin
      check("rx_valid", rx_valid, exp_rx_valid);
      check("rx_data", rx_data, exp_rx_data);
      check("overrun", overrun, exp_overrun);
      check("underrun", underrun, exp_underrun);
      check("tx_ready", tx_ready, tx_q.size() == 0);
      check("idle_miso", MISO, 1'b0);
      check("idle_frame_err", frame_err, 1'b0);
    end
  end

  task automatic resolve_slot();
    if (slot_pending) begin
      slot_pending = 1'b0;
      if (tx_q.size() > 0) slot_word = tx_q.pop_front();
      else begin
        slot_word    = '0;
        exp_underrun = 1'b1;
      end
    end
  endtask

  task automatic word_landed(input logic [DL-1:0] w);
    if (exp_rx_valid) exp_overrun = 1'b1;
    else begin
      exp_rx_data = w;
      if (rx_ready) exp_got.push_back(w);
      else exp_rx_valid = 1'b1;
    end
    slot_pending = 1'b1;
  endtask

  task automatic load_tx(input logic [DL-1:0] w);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 400) begin
      cyc(1);
      n++;
    end
    check("tx_ready_wait", tx_ready, 1'b1);
    tx_data  = w;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
    tx_q.push_back(w);
  endtask

  task automatic frame_begin();
    chk_en       = 1'b0;
    SS_n         = 1'b0;
    active       = 1'b1;
    slot_pending = 1'b1;
    bits_in_word = 0;
  endtask

  task automatic send_bits(input logic [DL-1:0] w, input int first, input int last,
                           output logic [DL-1:0] mo);
    mo = '0;
    for (int i = first; i < last; i++) begin
      MOSI = w[i];
      cyc(HALF);
      if (active) resolve_slot();
      check("miso_bit", MISO, active ? slot_word[i] : 1'b0);
      mo[i] = MISO;
      SCLK  = 1'b1;
      cyc(HALF);
      if (active) begin
        bits_in_word++;
        if (bits_in_word == DL) begin
          bits_in_word = 0;
          word_landed(w);
        end
      end
      SCLK = 1'b0;
    end
  endtask

  task automatic frame_end();
    cyc(HALF);
    if (active) begin
      resolve_slot();
      if (bits_in_word != 0) exp_ferr++;
    end
    SS_n   = 1'b1;
    active = 1'b0;
    cyc(8);
    chk_en = 1'b1;
    cyc(2);
    check("frame_err_pulses", ferr_cycles, exp_ferr);
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    cyc(1);
    clear_flags  = 1'b0;
    exp_overrun  = 1'b0;
    exp_underrun = 1'b0;
    cyc(2);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    reset  = 1'b1;
    cyc(3);
    reset = 1'b0;
    tx_q.delete();
    exp_rx_valid = 1'b0;
    exp_rx_data  = '0;
    exp_overrun  = 1'b0;
    exp_underrun = 1'b0;
    active       = 1'b0;
    slot_pending = 1'b0;
    bits_in_word = 0;
    check("rst_miso", MISO, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_overrun", overrun, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1);
  end

  initial begin
    SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = '0; tx_valid = 1'b0;
    rx_ready = 1'b1; clear_flags = 1'b0; reset = 1'b1;
    exp_ferr = 0; ferr_cycles = 0; slot_word = '0; chk_en = 1'b0;
    do_reset();
    chk_en = 1'b1;
    cyc(4);

    // 1: single word, A5 out / 3C in; trailing slot finds buffer empty
    load_tx(8'hA5);
    cyc(2);
    frame_begin();
    send_bits(8'h3C, 0, DL, mo1);
    frame_end();
    check("t1_miso_word", mo1, 8'hA5);
    check("t1_rx_data", rx_data, 8'h3C);
    check("t1_underrun", underrun, 1'b1);
    pulse_clear();

    // 2: back-to-back words, buffer refilled during the frame
    load_tx(8'h11);
    cyc(2);
    frame_begin();
    fork
      begin
        send_bits(8'hC3, 0, DL, mo1);
        send_bits(8'h7E, 0, DL, mo2);
      end
      begin
        load_tx(8'h22);
        load_tx(8'h33);
      end
    join
    frame_end();
    check("t2_miso_w1", mo1, 8'h11);
    check("t2_miso_w2", mo2, 8'h22);
    check("t2_rx_data", rx_data, 8'h7E);
    check("t2_overrun", overrun, 1'b0);
    check("t2_underrun", underrun, 1'b0);

    // 3: consumer stalled across two words -> overrun, first word kept
    rx_ready = 1'b0;
    cyc(2);
    frame_begin();
    send_bits(8'h5A, 0, DL, mo1);
    send_bits(8'hA6, 0, DL, mo2);
    frame_end();
    check("t3_rx_data", rx_data, 8'h5A);
    check("t3_rx_valid", rx_valid, 1'b1);
    check("t3_overrun", overrun, 1'b1);
    pulse_clear();
    check("t3_overrun_cleared", overrun, 1'b0);
    chk_en = 1'b0;
    rx_ready = 1'b1;
    cyc(1);
    exp_rx_valid = 1'b0;
    exp_got.push_back(8'h5A);
    chk_en = 1'b1;
    cyc(2);

    // 4: empty tx buffer at frame start
    frame_begin();
    send_bits(8'h0F, 0, DL, mo1);
    frame_end();
    check("t4_miso_word", mo1, 8'h00);
    check("t4_underrun", underrun, 1'b1);
    check("t4_tx_ready", tx_ready, 1'b1);
    check("t4_rx_data", rx_data, 8'h0F);
    pulse_clear();

    // 5: SS_n released after 5 bits, then a clean frame
    load_tx(8'hC6);
    cyc(2);
    frame_begin();
    send_bits(8'hFF, 0, 5, mo1);
    frame_end();
    check("t5_frame_err_count", ferr_cycles, 1);
    check("t5_rx_valid", rx_valid, 1'b0);
    check("t5_rx_data", rx_data, 8'h0F);
    load_tx(8'h81);
    cyc(2);
    frame_begin();
    send_bits(8'h69, 0, DL, mo1);
    frame_end();
    check("t5_miso_word", mo1, 8'h81);
    check("t5_rx_data_next", rx_data, 8'h69);
    pulse_clear();

    // 6: reset mid-frame; remainder ignored, next frame works
    load_tx(8'h3E);
    cyc(2);
    frame_begin();
    send_bits(8'hD2, 0, 3, mo1);
    do_reset();
    send_bits(8'hD2, 3, DL, mo1);
    frame_end();
    check("t6_rx_valid", rx_valid, 1'b0);
    check("t6_rx_data", rx_data, 8'h00);
    load_tx(8'h44);
    cyc(2);
    frame_begin();
    send_bits(8'h2B, 0, DL, mo1);
    frame_end();
    check("t6_miso_word", mo1, 8'h44);
    check("t6_rx_data_next", rx_data, 8'h2B);

    check("rx_word_count", got.size(), exp_got.size());
    for (int i = 0; i < exp_got.size() && i < got.size(); i++)
      check("rx_word", got[i], exp_got[i]);
    check("total_frame_err", ferr_cycles, exp_ferr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
